// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard unit: scoreboard entry
// layout, the register-file select code and the operand-select width.
package pipe_pkg;

    // Scoreboard entries hold register numbers at a fixed width so the struct
    // can be shared across NREG settings; NREG is limited to 2**WR_MAX_W.
    localparam int WR_MAX_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic [WR_MAX_W-1:0] wr;
        logic                load;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return (depth + 1 <= 2) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Youngest-producer operand select and load-use hazard detect for one
// decode source operand.
module pipe_fwd_sel
    import pipe_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = sel_w(DEPTH)
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [AW-1:0]         src,
    input  logic                  use_src,
    input  logic [DEPTH*SIZE-1:0] stage_data,
    input  logic [SIZE-1:0]       rf_data,
    output logic [SW-1:0]         sel,
    output logic [SIZE-1:0]       data,
    output logic                  hazard
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel    = SW'(FWD_RF);
        data   = rf_data;
        hazard = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k-1].valid && entries[k-1].we && use_src &&
                (src != '0) && (entries[k-1].wr == WR_MAX_W'(src))) begin
                sel    = SW'(k);
                data   = stage_data[(k-1)*SIZE +: SIZE];
                hazard = entries[k-1].load && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard, forwarding select and stall/flush control between decode and the
// downstream stages, with saturating stall and flush event counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int NREG       = 32,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int AW        = $clog2(NREG),
    localparam int SW        = sel_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [AW-1:0]         id_rs,
    input  logic [AW-1:0]         id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic                  id_we,
    input  logic [AW-1:0]         id_wr,
    input  logic                  id_load,
    input  logic                  br_taken,
    input  logic [DEPTH*SIZE-1:0] stage_data,
    input  logic [SIZE-1:0]       rf_rs_data,
    input  logic [SIZE-1:0]       rf_rt_data,
    output logic [SW-1:0]         rs_sel,
    output logic [SW-1:0]         rt_sel,
    output logic [SIZE-1:0]       rs_data,
    output logic [SIZE-1:0]       rt_data,
    output logic                  stall,
    output logic                  flush,
    output logic                  issue,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    sb_entry_t [DEPTH-1:0] sb;
    sb_entry_t             new_entry;
    logic                  rs_hazard;
    logic                  rt_hazard;

    pipe_fwd_sel #(
        .SIZE(SIZE), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
    ) u_rs_sel (
        .entries(sb), .src(id_rs), .use_src(id_use_rs), .stage_data(stage_data),
        .rf_data(rf_rs_data), .sel(rs_sel), .data(rs_data), .hazard(rs_hazard)
    );

    pipe_fwd_sel #(
        .SIZE(SIZE), .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .SW(SW)
    ) u_rt_sel (
        .entries(sb), .src(id_rt), .use_src(id_use_rt), .stage_data(stage_data),
        .rf_data(rf_rt_data), .sel(rt_sel), .data(rt_data), .hazard(rt_hazard)
    );

    // Flush is held off while reset is asserted so reset outputs are clean.
    assign flush = br_taken & rst_n;
    assign stall = id_valid & (rs_hazard | rt_hazard) & ~br_taken;
    assign issue = id_valid & ~stall & ~flush;

    always_comb begin
        new_entry       = '0;
        new_entry.valid = issue;
        new_entry.we    = issue & id_we;
        new_entry.wr    = WR_MAX_W'(id_wr);
        new_entry.load  = issue & id_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                sb[k] <= sb[k-1];
            end
            sb[0] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed and randomized checks of pipe_hazard_unit against a model of the
// in-flight instruction window kept in the bench.
module tb_pipe_hazard_unit;

    localparam int SIZE       = 32;
    localparam int NREG       = 32;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int CNT_W      = 4;
    localparam int AW         = 5;
    localparam int SW         = 2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  id_valid = 1'b0;
    logic [AW-1:0]         id_rs = '0;
    logic [AW-1:0]         id_rt = '0;
    logic                  id_use_rs = 1'b0;
    logic                  id_use_rt = 1'b0;
    logic                  id_we = 1'b0;
    logic [AW-1:0]         id_wr = '0;
    logic                  id_load = 1'b0;
    logic                  br_taken = 1'b0;
    logic [DEPTH*SIZE-1:0] stage_data = '0;
    logic [SIZE-1:0]       rf_rs_data = '0;
    logic [SIZE-1:0]       rf_rt_data = '0;
    logic [SW-1:0]         rs_sel;
    logic [SW-1:0]         rt_sel;
    logic [SIZE-1:0]       rs_data;
    logic [SIZE-1:0]       rt_data;
    logic                  stall;
    logic                  flush;
    logic                  issue;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    pipe_hazard_unit #(
        .SIZE(SIZE), .NREG(NREG), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_wr(id_wr),
        .id_load(id_load), .br_taken(br_taken), .stage_data(stage_data),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .rs_sel(rs_sel), .rt_sel(rt_sel),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .flush(flush), .issue(issue),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // In-flight window: slot k is the instruction currently in stage k.
    typedef struct {
        bit real_insn;
        bit writes;
        int dest;
        bit is_load;
    } insn_t;

    insn_t window[1:DEPTH];
    int    n_stalls;
    int    n_flushes;
    int    checks;
    int    errors;
    bit    exp_issue;
    bit    exp_stall;
    bit    exp_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nearest producer of src, searching from the youngest stage outward.
    task automatic find_producer(input int src, input bit used, output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (used && src != 0) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (window[k].real_insn && window[k].writes && window[k].dest == src) begin
                    sel = k;
                    hz  = window[k].is_load && (k < LOAD_STAGE);
                    break;
                end
            end
        end
    endtask

    function automatic logic [SIZE-1:0] pick(input int sel, input logic [SIZE-1:0] rf);
        logic [DEPTH*SIZE-1:0] bus;
        bus = stage_data;
        return (sel == 0) ? rf : bus[(sel-1)*SIZE +: SIZE];
    endfunction

    task automatic clear_model();
        for (int k = 1; k <= DEPTH; k++) window[k] = '{0, 0, 0, 0};
        n_stalls  = 0;
        n_flushes = 0;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit we, input int wr, input bit ld, input bit br);
        id_valid   = v;
        id_rs      = AW'(rs);
        id_rt      = AW'(rt);
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_we      = we;
        id_wr      = AW'(wr);
        id_load    = ld;
        br_taken   = br;
        stage_data = {$urandom, $urandom, $urandom};
        rf_rs_data = $urandom;
        rf_rt_data = $urandom;
    endtask

    task automatic do_checks();
        int s_sel, t_sel;
        bit s_hz, t_hz;
        find_producer(int'(id_rs), id_use_rs, s_sel, s_hz);
        find_producer(int'(id_rt), id_use_rt, t_sel, t_hz);
        exp_flush = br_taken && rst_n;
        exp_stall = id_valid && (s_hz || t_hz) && !br_taken;
        exp_issue = id_valid && !exp_stall && !exp_flush;
        chk("stall", 64'(stall), 64'(exp_stall));
        chk("flush", 64'(flush), 64'(exp_flush));
        chk("issue", 64'(issue), 64'(exp_issue));
        chk("stall_cnt", 64'(stall_cnt), 64'(n_stalls));
        chk("flush_cnt", 64'(flush_cnt), 64'(n_flushes));
        if (!exp_stall) begin
            chk("rs_sel", 64'(rs_sel), 64'(s_sel));
            chk("rt_sel", 64'(rt_sel), 64'(t_sel));
            chk("rs_data", 64'(rs_data), 64'(pick(s_sel, rf_rs_data)));
            chk("rt_data", 64'(rt_data), 64'(pick(t_sel, rf_rt_data)));
        end
    endtask

    task automatic clock_model();
        @(posedge clk);
        if (rst_n) begin
            for (int k = DEPTH; k >= 2; k--) window[k] = window[k-1];
            if (exp_issue) window[1] = '{1, id_we, int'(id_wr), id_load};
            else           window[1] = '{0, 0, 0, 0};
            if (exp_stall && n_stalls < CNT_MAX)  n_stalls++;
            if (exp_flush && n_flushes < CNT_MAX) n_flushes++;
        end
        #1;
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit we, input int wr, input bit ld, input bit br);
        drive(v, rs, rt, urs, urt, we, wr, ld, br);
        #1;
        do_checks();
        clock_model();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_model();

        // reset values with a live decode instruction: issue follows id_valid
        step(1, 3, 4, 1, 1, 1, 5, 1, 0);
        step(1, 3, 4, 1, 1, 1, 5, 0, 0);
        rst_n = 1'b1;

        // ALU chain: producer then consumer forwards from stage 1
        step(1, 1, 2, 0, 0, 1, 3, 0, 0);
        step(1, 3, 0, 1, 0, 1, 7, 0, 0);
        chk("alu_fwd_sel", 64'(window[1].dest), 64'd7);

        // load-use: one stall, then forward both operands from stage 2
        step(1, 1, 1, 0, 0, 1, 5, 1, 0);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0);
        step(1, 5, 5, 1, 1, 1, 6, 0, 0);

        // youngest wins; r0 never forwards
        step(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4, 0, 0);
        step(1, 4, 0, 1, 1, 0, 0, 0, 0);

        // load-use hazard together with a taken branch: flush wins
        step(1, 0, 0, 0, 0, 1, 9, 1, 0);
        step(1, 9, 9, 1, 1, 1, 2, 0, 1);
        step(1, 9, 9, 1, 1, 1, 2, 0, 0);

        // enough load-use stalls to saturate the 4-bit stall counter
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, 1, 1, 1, 0);
            step(1, 1, 2, 1, 1, 1, 2, 0, 0);
            step(1, 1, 2, 1, 1, 1, 2, 0, 0);
        end
        chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));

        // reset asserted mid-cycle with three valid producers in flight
        step(1, 0, 0, 0, 0, 1, 10, 0, 0);
        step(1, 0, 0, 0, 0, 1, 11, 1, 0);
        step(1, 0, 0, 0, 0, 1, 12, 0, 0);
        drive(1, 10, 12, 1, 1, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        clear_model();
        #1;
        do_checks();
        chk("rst_rs_sel", 64'(rs_sel), 64'd0);
        chk("rst_rt_sel", 64'(rt_sel), 64'd0);
        clock_model();
        rst_n = 1'b1;

        // randomized traffic over a small register pool to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 5),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised scoreboard, forwarding and stall/flush controller for the in-order pipeline. It sits between decode and the downstream stages. It tracks the destination register of every in-flight instruction across DEPTH post-decode stages and selects the youngest producer for each decode operand. It generates load-use stalls and branch flushes, and keeps saturating event counters. It supersedes the fixed EX/MEM-only forwarding with a depth- and latency-configurable unit.

## Interface
- SIZE, 32, data width of operands and forwarded results
- NREG, 32, architectural register count; AW = $clog2(NREG); register 0 hardwired zero
- DEPTH, 3, tracked stages after decode (stage 1 = EX … stage DEPTH = last writing stage); DEPTH ≥ 2
- LOAD_STAGE, 2, first stage index at which load data is valid; 1 < LOAD_STAGE ≤ DEPTH
- CNT_W, 16, event counter width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  AW  decode source registers
- id_use_rs, id_use_rt  in  1  operand actually read
- id_we  in  1  decode instruction writes a register
- id_wr  in  AW  decode destination register
- id_load  in  1  decode instruction is a load
- br_taken  in  1  branch in stage 1 resolved taken
- stage_data  in  DEPTH*SIZE  flattened result bus; slice k-1 = value produced by instruction in stage k
- rf_rs_data, rf_rt_data  in  SIZE  register-file read data
- rs_sel, rt_sel  out  $clog2(DEPTH+1)  0 = register file, k = forward from stage k
- rs_data, rt_data  out  SIZE  selected operand values
- stall  out  1  hold PC and IF/ID, inject bubble
- flush  out  1  squash IF/ID contents
- issue  out  1  decode instruction enters stage 1 this cycle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counts

## Operation
- Scoreboard: DEPTH entries {valid, we, wr, load}. Each rising edge: entry[k] ← entry[k-1] for k ≥ 2; entry[1] ← decode fields if issue, else bubble (valid=0). Downstream stages never freeze.
- issue = id_valid & ~stall & ~flush.
- Per operand: match[k] = entry[k].valid & we & wr == src & src ≠ 0 & use. Youngest match (smallest k) wins and gives sel = k, data = stage_data slice k-1. No match gives sel = 0, data = rf data.
- Load-use: if the winning match is a load with k < LOAD_STAGE, raise stall (combinational); sel/data still reported but are don't-care.
- stall = id_valid & (rs_hazard | rt_hazard) & ~br_taken.
- flush = br_taken. Flush has priority over stall. The decode instruction is dropped and a bubble enters stage 1.
- Counters: stall_cnt +1 per cycle with stall=1, flush_cnt +1 per cycle with flush=1; both saturate at 2^CNT_W-1, no wrap.
- Register 0 never forwards and never stalls.

## Timing
- sel, data, stall, flush, issue are combinational from current scoreboard and decode inputs; same-cycle use by decode/fetch.
- Scoreboard and counters update on rising edge only.
- Load issued at cycle t: dependent instruction decoded at t+1 stalls for LOAD_STAGE-1 cycles, then issues with sel = LOAD_STAGE. Defaults: stall at t+1, forward from stage 2 at t+2.
- ALU producer issued at t: dependent instruction at t+1 forwards sel=1, no stall.
- Producer in stage DEPTH is still forwarded; after it retires, the RF value is used (RF is write-before-read).
- Reset (any time, asynchronous): all entries invalid, stall=0, flush=0, issue=id_valid, sel=0, counters 0. Assertion mid-operation discards in-flight tracking immediately.

## Structure
- pipe_pkg: sb_entry_t struct {valid, we, wr, load}, FWD_RF = 0 constant, sel-width function.
- Sub-module pipe_fwd_sel: priority youngest-match and load-hazard detect for one operand, instantiated for rs and rt.
- Top holds the scoreboard shift register, stall/flush/issue logic and counters.

## Test plan
- ALU chain: add r3 issued, next instruction reads r3 → rs_sel=1, rs_data = stage_data[0], stall=0.
- Load-use: lw r5 then add r6,r5,r5 back-to-back (defaults) → stall=1 one cycle, bubble in stage 1, then rs_sel=rt_sel=2, stall_cnt=1.
- Youngest wins: r4 written by instructions in stages 1 and 3 → rs_sel=1; r0 matches anywhere → sel=0.
- Flush vs stall: load-use hazard and br_taken in the same cycle → flush=1, stall=0, issue=0, flush_cnt +1, stall_cnt unchanged.
- Saturation: CNT_W=4, hold stall 20 cycles → stall_cnt stops at 15.
- Reset mid-stream: rst_n low with 3 valid entries → next cycle every sel=0, stall=0, counters 0.
